// File: rtl/tx_buffer.sv
// -----------------------------------------------------------------------------
// tx_buffer
//   FIFO-buffered parallel-to-serial transmitter. Words written on in_i are
//   queued in a DEPTH-entry FIFO and shifted out MSB first on out_o, one bit
//   per clk edge with clken_i=1. Consecutive words stream with no gap bit.
//
// Ports
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset
//   in_i         parallel word to transmit (WIDTH bits)
//   wr_en_i      write strobe for in_i, sampled on every clk edge
//   clken_i      bit-rate enable; one serial bit per enabled edge
//   out_o        registered serial data, MSB first
//   out_valid_o  registered; 1 while out_o carries a real data bit
//   full_o       registered; FIFO holds DEPTH words
//   empty_o      registered; FIFO holds no words
//   count_o      registered FIFO occupancy (word in the shifter not counted)
//   overflow_o   sticky flag, set by a write attempted while full
// -----------------------------------------------------------------------------
module tx_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_i,
    input  logic             wr_en_i,
    input  logic             clken_i,
    output logic             out_o,
    output logic             out_valid_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o,
    output logic             overflow_o
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [0:0]    ST_IDLE   = 1'b0;
    localparam logic [0:0]    ST_SHIFT  = 1'b1;
    localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] BIT_ZERO  = {BW{1'b0}};
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [0:0]       state_q, state_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             overflow_q, overflow_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;

    logic             wr_acc_s;
    logic             pop_s;
    logic             last_bit_s;
    logic [WIDTH-1:0] head_s;

    // Write acceptance and pop decision; both look only at registered flags,
    // so a pop on the same edge never lets a write into a full FIFO.
    always_comb begin
        wr_acc_s   = wr_en_i & ~full_q;
        last_bit_s = (bitcnt_q == BIT_LAST);
        head_s     = mem_q[rptr_q];
        if (state_q == ST_IDLE) begin
            pop_s = ~empty_q;
        end else begin
            pop_s = ~empty_q & clken_i & last_bit_s;
        end
    end

    // FIFO pointers, occupancy, status flags and sticky overflow.
    always_comb begin
        if (wr_acc_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
        case ({wr_acc_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == CNT_ZERO);
        if (wr_en_i & full_q) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Serializer next state: loading from the FIFO in IDLE ignores clken,
    // while every change to out/out_valid waits for an enabled edge.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (clken_i) begin
                    out_d       = 1'b0;
                    out_valid_d = 1'b0;
                end else begin
                    out_d       = out_q;
                    out_valid_d = out_valid_q;
                end
                if (pop_s) begin
                    shreg_d  = head_s;
                    bitcnt_d = BIT_ZERO;
                    state_d  = ST_SHIFT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (clken_i) begin
                    out_d       = shreg_q[WIDTH-1];
                    out_valid_d = 1'b1;
                    if (!last_bit_s) begin
                        shreg_d  = shreg_q << 1;
                        bitcnt_d = bitcnt_q + BIT_ONE;
                    end else if (pop_s) begin
                        // Back-to-back word: reload in place of the final shift.
                        shreg_d  = head_s;
                        bitcnt_d = BIT_ZERO;
                    end else begin
                        shreg_d  = shreg_q << 1;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wptr_q] <= in_i;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wptr_q      <= {AW{1'b0}};
            rptr_q      <= {AW{1'b0}};
            count_q     <= CNT_ZERO;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            shreg_q     <= {WIDTH{1'b0}};
            bitcnt_q    <= BIT_ZERO;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
        end
    end

    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;

endmodule
